// File: rtl/snow64_fake_instr_mem_responder.sv
// snow64_fake_instr_mem_responder
//   Memory-side stand-in for the instruction-cache line-fill port. It accepts a
//   one-cycle read request and returns the full 256-bit line a fixed LATENCY
//   cycles later. Only one request can be outstanding. The backing array is
//   preloaded through a write port, and that port works in every state.
//
// Optional feature: SNOW64_FAKE_INSTR_MEM_OOR_ERR_EN
//   Adds out_err. A request whose line index is >= DEPTH_LINES still completes
//   with the normal latency, but it returns zero data and pulses out_err
//   together with out_valid. Without the macro the index wraps modulo
//   DEPTH_LINES.
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   in_req/in_addr  line-fill request; line index = in_addr[63:3]
//   in_wr_en/in_wr_line/in_wr_data  preload write port
//   out_valid       one-cycle response strobe
//   out_data        line data; held after the strobe
//   out_busy        request outstanding
//   out_err         out-of-range strobe (only with the macro)
module snow64_fake_instr_mem_responder #(
  parameter int LATENCY     = 4,
  parameter int DEPTH_LINES = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_req,
  input  logic [63:0]                    in_addr,
  input  logic                           in_wr_en,
  input  logic [$clog2(DEPTH_LINES)-1:0] in_wr_line,
  input  logic [255:0]                   in_wr_data,
  output logic                           out_valid,
  output logic [255:0]                   out_data,
`ifdef SNOW64_FAKE_INSTR_MEM_OOR_ERR_EN
  output logic                           out_err,
`endif
  output logic                           out_busy
);
  localparam int AW = $clog2(DEPTH_LINES);
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t         state, state_n;
  logic [7:0]     cnt, cnt_n;
  logic [AW-1:0]  line_q, req_idx, rd_idx;
  logic           accept, load;
  logic [255:0]   mem [DEPTH_LINES];

  assign req_idx = in_addr[AW+2:3];

`ifdef SNOW64_FAKE_INSTR_MEM_OOR_ERR_EN
  logic oor_q, req_oor, rd_oor, err_q;
  assign req_oor = |in_addr[63:AW+3];
  logic unused_addr;
  assign unused_addr = ^in_addr[2:0];
  assign out_err = (state == ST_RESP) && err_q;
`else
  // The offset bits and the index bits above the array size are dropped.
  logic unused_addr;
  assign unused_addr = ^{in_addr[2:0], in_addr[63:AW+3]};
`endif

  // The preload port has no reset, so a write on the reset edge still commits.
  always_ff @(posedge clk) begin
    if (in_wr_en) mem[in_wr_line] <= in_wr_data;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    load    = 1'b0;
    rd_idx  = line_q;
`ifdef SNOW64_FAKE_INSTR_MEM_OOR_ERR_EN
    rd_oor  = oor_q;
`endif
    case (state)
      ST_IDLE: if (in_req) begin
        accept = 1'b1;
        cnt_n  = CNT_INIT;
        if (LATENCY == 1) begin
          // A single-cycle latency reads the array on the accepting edge.
          load    = 1'b1;
          rd_idx  = req_idx;
`ifdef SNOW64_FAKE_INSTR_MEM_OOR_ERR_EN
          rd_oor  = req_oor;
`endif
          state_n = ST_RESP;
        end else begin
          state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_n = cnt - 8'd1;
        if (cnt == 8'd1) begin
          load    = 1'b1;
          state_n = ST_RESP;
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign out_valid = (state == ST_RESP);
  assign out_busy  = (state != ST_IDLE);

  // The array is read with nonblocking semantics, so a write to the same
  // line on the load edge is not visible and the old data is returned.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= 8'd0;
      line_q   <= '0;
      out_data <= '0;
`ifdef SNOW64_FAKE_INSTR_MEM_OOR_ERR_EN
      oor_q    <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        line_q <= req_idx;
`ifdef SNOW64_FAKE_INSTR_MEM_OOR_ERR_EN
        oor_q  <= req_oor;
`endif
      end
      if (load) begin
`ifdef SNOW64_FAKE_INSTR_MEM_OOR_ERR_EN
        out_data <= rd_oor ? '0 : mem[rd_idx];
        err_q    <= rd_oor;
`else
        out_data <= mem[rd_idx];
`endif
      end
    end
  end
endmodule
